// File: rtl/if_id_stage_reg.sv
// if_id_stage_reg: IF/ID pipeline register with stall, multi-slot squash window and squash counter
module if_id_stage_reg #(
    parameter int                 INSTR_W      = 16,
    parameter int                 PC_W         = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR    = 16'h1800,
    parameter int                 FLUSH_CYCLES = 1,
    parameter int                 CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    seq_pc_in,
    input  logic               valid_in,
    input  logic               branch,
    input  logic               branch_haz,
    input  logic               cnt_clr,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    seq_pc_out,
    output logic               valid_out,
    output logic               squash_active,
    output logic [CNT_W-1:0]   squash_cnt
);

    typedef enum logic {IDLE, SQUASH} state_t;

    localparam logic [3:0]       REM_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    generate
        if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
            $error("if_id_stage_reg: FLUSH_CYCLES must be in 1..15");
        end
    endgenerate

    state_t     state, state_nxt;
    logic [3:0] remaining, rem_nxt;
    logic       flush, bubble, pass;

    assign flush         = branch | branch_haz;
    assign squash_active = state == SQUASH;

    // Decide the load kind and the next window state; flush beats stall, stall beats the window
    always_comb begin
        state_nxt = state;
        rem_nxt   = remaining;
        bubble    = 1'b0;
        pass      = 1'b0;
        if (flush) begin
            bubble    = 1'b1;
            rem_nxt   = REM_INIT;
            state_nxt = FLUSH_CYCLES > 1 ? SQUASH : IDLE;
        end else if (en && state == SQUASH) begin
            bubble    = 1'b1;
            rem_nxt   = remaining - 4'd1;
            state_nxt = remaining == 4'd1 ? IDLE : SQUASH;
        end else if (en) begin
            pass = 1'b1;
        end
    end

    // Squash window state; a stall leaves it frozen because the decode above keeps it
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= 4'd0;
        end else begin
            state     <= state_nxt;
            remaining <= rem_nxt;
        end
    end

    // Pipeline payload: bubble loads a NOP, pass copies fetch, otherwise hold
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            instr_out  <= NOP_INSTR;
            seq_pc_out <= '0;
            valid_out  <= 1'b0;
        end else if (pass) begin
            instr_out  <= instr_in;
            seq_pc_out <= seq_pc_in;
            valid_out  <= valid_in;
        end
    end

    // Saturating count of real instructions thrown away; clear wins over increment
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            squash_cnt <= '0;
        end else if (bubble && valid_in && squash_cnt != CNT_MAX) begin
            squash_cnt <= squash_cnt + 1'b1;
        end
    end

endmodule
